alu_result_buf: RTL and testbench
=================================

Name: alu_result_buf

Overview:
- Downstream stage of the 16-bit ALU. Captures each ALU result (Out, Ofl, Z) plus a destination tag into a small FIFO.
- Presents results to the writeback stage over a valid/ready handshake.
- Keeps a sticky overflow status and a saturating count of accepted results for the control logic.
- Decouples ALU issue timing from writeback stalls.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- TAGW, 3, destination-register tag width in bits.
- CNTW, 8, width of the accepted-result counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  buffer can accept a result.
- in_data  input  16  ALU Out.
- in_ofl  input  1  ALU Ofl.
- in_z  input  1  ALU Z.
- in_tag  input  TAGW  destination tag issued with the operation.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head entry.
- out_data  output  16  head result.
- out_ofl  output  1  head overflow flag.
- out_z  output  1  head zero flag.
- out_tag  output  TAGW  head tag.
- clr_sticky  input  1  clear sticky overflow.
- ofl_sticky  output  1  set once any accepted result had ofl=1.
- acc_cnt  output  CNTW  accepted-result count, saturating.
- out_par  output  1  head parity; present only with the optional feature.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers and occupancy are cleared to 0.
  - out_valid=0, in_ready=1, ofl_sticky=0, acc_cnt=0.
  - out_data, out_ofl, out_z, out_tag, out_par all read 0 while empty.
  - Reset in mid-operation discards all entries with no drain.
  - Reset overrides push, pop and clr_sticky in the same cycle.
- Push occurs when in_valid and in_ready are both high. The entry {in_data, in_ofl, in_z, in_tag} is written at the write pointer.
- Pop occurs when out_valid and out_ready are both high. The read pointer advances.
- Ready and valid:
  - in_ready = (occupancy != DEPTH), registered-state based; it has no combinational path from out_ready.
  - out_valid = (occupancy != 0).
- Latency: a pushed entry appears on the outputs the cycle after the push. There is no same-cycle bypass when the buffer is empty.
- Outputs are driven combinationally from the head entry. They must hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop (only possible with 0 < occupancy < DEPTH): both take effect and occupancy is unchanged.
- When full, in_ready=0, so a push cannot coincide with a pop. in_ready returns to 1 the cycle after a pop.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- ofl_sticky:
  - Next value is 1 if a push has in_ofl=1.
  - Otherwise it is 0 if clr_sticky=1.
  - Otherwise it holds.
  - Set wins over clear in the same cycle.
- acc_cnt increments by 1 per push and saturates at 2^CNTW-1. It is not affected by pops or clr_sticky.
- in_valid with in_ready=0 is ignored: no state change and no count.
- Upstream must hold in_* stable until the transfer occurs.

Optional Feature:
- Macro: ALU_RESULT_BUF_PARITY_EN.
- Defined:
  - Each entry also stores an even-parity bit computed at push: XOR of in_data[15:0], in_ofl and in_z.
  - out_par presents the stored bit for the head entry and is 0 when empty.
  - Storage width grows by 1 bit per entry.
- Undefined: the out_par port is absent and no parity storage exists. All other behaviour is identical.

Test Plan:
- Reset, then idle for 3 cycles -> out_valid=0, in_ready=1, ofl_sticky=0, acc_cnt=0 throughout.
- Push data 0x1234, tag 5, ofl 0, z 0 with out_ready=1 -> out_valid=1 with out_data=0x1234, out_tag=5 on the next cycle, then empty the cycle after; acc_cnt=1.
- Hold out_ready=0 and push 0xAAAA, then 0x5555 -> in_ready=0 after the second push, a third push attempt (0xFFFF) is ignored, acc_cnt=2. Raise out_ready -> 0xAAAA then 0x5555 in order, and in_ready=1 the cycle after the first pop.
- With occupancy 1, push and pop in the same cycle -> occupancy stays 1, order is preserved, and the wrap-around of both pointers is exercised over 5 consecutive transfers.
- Push with ofl=1 while clr_sticky=1 in the same cycle -> ofl_sticky=1. Next cycle clr_sticky=1 with no push -> ofl_sticky=0.
- Fill to 2 entries, assert rst_n=0 together with in_valid=1 and clr_sticky=1 -> next cycle out_valid=0, acc_cnt=0, ofl_sticky=0.
- With the macro defined, push 0x0001 with ofl=0, z=0 -> out_par=1; push 0x0003 -> out_par=0.

Source files
------------

// File: rtl/alu_result_buf.sv
// rtl/alu_result_buf.sv - ALU result FIFO with valid/ready handshake, sticky overflow and accepted count (optional parity: ALU_RESULT_BUF_PARITY_EN)
module alu_result_buf #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 3,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_data,
    input  logic            in_ofl,
    input  logic            in_z,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic            out_ofl,
    output logic            out_z,
    output logic [TAGW-1:0] out_tag,
    input  logic            clr_sticky,
    output logic            ofl_sticky,
    output logic [CNTW-1:0] acc_cnt
`ifdef ALU_RESULT_BUF_PARITY_EN
    ,
    output logic            out_par
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    logic [15:0]     mem_data [0:DEPTH-1];
    logic            mem_ofl  [0:DEPTH-1];
    logic            mem_z    [0:DEPTH-1];
    logic [TAGW-1:0] mem_tag  [0:DEPTH-1];
`ifdef ALU_RESULT_BUF_PARITY_EN
    logic            mem_par  [0:DEPTH-1];
`endif

    // Ready/valid come only from registered occupancy, so no out_ready -> in_ready path
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry is presented directly; outputs are forced to zero while empty
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ofl  = out_valid ? mem_ofl[rd_ptr]  : 1'b0;
    assign out_z    = out_valid ? mem_z[rd_ptr]    : 1'b0;
    assign out_tag  = out_valid ? mem_tag[rd_ptr]  : '0;
`ifdef ALU_RESULT_BUF_PARITY_EN
    assign out_par  = out_valid ? mem_par[rd_ptr]  : 1'b0;
`endif

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: contents are only visible through a valid head
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_ofl[wr_ptr]  <= in_ofl;
            mem_z[wr_ptr]    <= in_z;
            mem_tag[wr_ptr]  <= in_tag;
`ifdef ALU_RESULT_BUF_PARITY_EN
            mem_par[wr_ptr]  <= ^{in_data, in_ofl, in_z};
`endif
        end
    end

    // Sticky overflow: an overflowing push beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ofl_sticky <= 1'b0;
        end else if (push && in_ofl) begin
            ofl_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ofl_sticky <= 1'b0;
        end
    end

    // Saturating count of accepted results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (push && (acc_cnt != '1)) begin
            acc_cnt <= acc_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_buf.sv
// tb/tb_alu_result_buf.sv - self-checking bench for alu_result_buf (table vectors plus scoreboard)
module tb_alu_result_buf;

    localparam int DEPTH = 2;
    localparam int TAGW  = 3;
    localparam int CNTW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_data;
    logic            in_ofl;
    logic            in_z;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic            out_ofl;
    logic            out_z;
    logic [TAGW-1:0] out_tag;
    logic            clr_sticky;
    logic            ofl_sticky;
    logic [CNTW-1:0] acc_cnt;
`ifdef ALU_RESULT_BUF_PARITY_EN
    logic            out_par;
`endif

    alu_result_buf #(.DEPTH(DEPTH), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ofl     (in_ofl),
        .in_z       (in_z),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ofl    (out_ofl),
        .out_z      (out_z),
        .out_tag    (out_tag),
        .clr_sticky (clr_sticky),
        .ofl_sticky (ofl_sticky),
        .acc_cnt    (acc_cnt)
`ifdef ALU_RESULT_BUF_PARITY_EN
        ,
        .out_par    (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     d;
        logic            o;
        logic            z;
        logic [TAGW-1:0] t;
        logic            p;
    } entry_t;

    typedef struct {
        logic            rst;
        logic            v;
        logic [15:0]     d;
        logic            o;
        logic            z;
        logic [TAGW-1:0] t;
        logic            ordy;
        logic            clr;
        logic            e_ov;
        logic            e_ir;
        logic [15:0]     e_d;
        logic            e_stk;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    entry_t          q[$];
    logic            m_stk;
    int unsigned     m_cnt;
    int              total = 0;
    int              bad   = 0;
    vec_t            tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic v, input logic [15:0] d, input logic o,
                                input logic z, input logic [TAGW-1:0] t, input logic ordy, input logic clr,
                                input logic e_ov, input logic e_ir, input logic [15:0] e_d,
                                input logic e_stk, input logic [CNTW-1:0] e_cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.o = o; r.z = z; r.t = t; r.ordy = ordy; r.clr = clr;
        r.e_ov = e_ov; r.e_ir = e_ir; r.e_d = e_d; r.e_stk = e_stk; r.e_cnt = e_cnt;
        return r;
    endfunction

    // Compare every DUT output with the scoreboard model state
    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("ofl_sticky", 32'(ofl_sticky), 32'(m_stk));
        chk("acc_cnt", 32'(acc_cnt), m_cnt);
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            chk("out_ofl", 32'(out_ofl), 32'(q[0].o));
            chk("out_z", 32'(out_z), 32'(q[0].z));
            chk("out_tag", 32'(out_tag), 32'(q[0].t));
`ifdef ALU_RESULT_BUF_PARITY_EN
            chk("out_par", 32'(out_par), 32'(q[0].p));
`endif
        end else begin
            chk("out_data_empty", 32'(out_data), 32'h0);
            chk("out_flags_empty", 32'({out_ofl, out_z, out_tag}), 32'h0);
`ifdef ALU_RESULT_BUF_PARITY_EN
            chk("out_par_empty", 32'(out_par), 32'h0);
`endif
        end
    endtask

    // Apply inputs just after a rising edge, then check on the falling edge
    task automatic drive(input logic rst, input logic v, input logic [15:0] d, input logic o, input logic z,
                         input logic [TAGW-1:0] t, input logic ordy, input logic clr);
        rst_n = ~rst; in_valid = v; in_data = d; in_ofl = o; in_z = z; in_tag = t;
        out_ready = ordy; clr_sticky = clr;
        @(negedge clk);
        check_outputs();
    endtask

    // Update the model with what the next rising edge does, then move past it
    task automatic advance();
        bit     push;
        bit     pop;
        entry_t e;
        if (!rst_n) begin
            q.delete();
            m_stk = 1'b0;
            m_cnt = 0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            pop  = (q.size() != 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.d = in_data; e.o = in_ofl; e.z = in_z; e.t = in_tag;
                e.p = ^{in_data, in_ofl, in_z};
                q.push_back(e);
                if (m_cnt < 255) m_cnt++;
            end
            if (push && in_ofl) m_stk = 1'b1;
            else if (clr_sticky) m_stk = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rst, input logic v, input logic [15:0] d, input logic o, input logic z,
                        input logic [TAGW-1:0] t, input logic ordy, input logic clr);
        drive(rst, v, d, o, z, t, ordy, clr);
        advance();
    endtask

    initial begin
        //            rst  v  data     o  z  tag ordy clr  e_ov e_ir e_d     stk cnt
        tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 0);
        tbl[3]  = mk(0, 1, 16'h1234, 0, 0, 5, 1, 0,   0, 1, 16'h0000, 0, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   1, 1, 16'h1234, 0, 1);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   0, 1, 16'h0000, 0, 1);
        tbl[6]  = mk(1, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 1);
        tbl[7]  = mk(0, 1, 16'hAAAA, 0, 0, 1, 0, 0,   0, 1, 16'h0000, 0, 0);
        tbl[8]  = mk(0, 1, 16'h5555, 0, 0, 2, 0, 0,   1, 1, 16'hAAAA, 0, 1);
        tbl[9]  = mk(0, 1, 16'hFFFF, 0, 0, 3, 0, 0,   1, 0, 16'hAAAA, 0, 2);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   1, 0, 16'hAAAA, 0, 2);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   1, 1, 16'h5555, 0, 2);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 2);
        tbl[13] = mk(0, 1, 16'h0101, 0, 0, 0, 0, 0,   0, 1, 16'h0000, 0, 2);
        tbl[14] = mk(0, 1, 16'h0202, 0, 0, 1, 1, 0,   1, 1, 16'h0101, 0, 3);
        tbl[15] = mk(0, 1, 16'h0303, 0, 0, 2, 1, 0,   1, 1, 16'h0202, 0, 4);
        tbl[16] = mk(0, 1, 16'h0000, 0, 1, 3, 1, 0,   1, 1, 16'h0303, 0, 5);
        tbl[17] = mk(0, 1, 16'h0505, 0, 0, 4, 1, 0,   1, 1, 16'h0000, 0, 6);
        tbl[18] = mk(0, 1, 16'h0606, 0, 0, 6, 1, 0,   1, 1, 16'h0505, 0, 7);
        tbl[19] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   1, 1, 16'h0606, 0, 8);
        tbl[20] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   0, 1, 16'h0000, 0, 8);
        tbl[21] = mk(0, 1, 16'h8000, 1, 0, 7, 1, 1,   0, 1, 16'h0000, 0, 8);
        tbl[22] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 1,   1, 1, 16'h8000, 1, 9);
        tbl[23] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,   0, 1, 16'h0000, 0, 9);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ofl = 1'b0; in_z = 1'b0; in_tag = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        m_stk = 1'b0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].z, tbl[i].t, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
            chk($sformatf("vec%0d_ofl_sticky", i), 32'(ofl_sticky), 32'(tbl[i].e_stk));
            chk($sformatf("vec%0d_acc_cnt", i), 32'(acc_cnt), 32'(tbl[i].e_cnt));
            advance();
        end

        // Reset overrides push, pop and clear: fill, set sticky, then reset with traffic present
        step(0, 1, 16'h1111, 1, 0, 1, 0, 0);
        step(0, 1, 16'h2222, 0, 0, 2, 0, 0);
        step(1, 1, 16'h3333, 1, 0, 3, 1, 1);
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
        chk("rst_override_out_valid", 32'(out_valid), 32'h0);
        chk("rst_override_acc_cnt", 32'(acc_cnt), 32'h0);
        chk("rst_override_sticky", 32'(ofl_sticky), 32'h0);
        advance();

        // Parity of head: 0x0001 is odd, 0x0003 is even
        step(0, 1, 16'h0001, 0, 0, 1, 0, 0);
        step(0, 1, 16'h0003, 0, 0, 2, 1, 0);
        step(0, 0, 16'h0000, 0, 0, 0, 1, 0);
        step(0, 0, 16'h0000, 0, 0, 0, 1, 0);

        // Streaming push/pop long enough to saturate the accepted counter
        for (int i = 0; i < 260; i++) begin
            step(0, 1, 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1, 1'($urandom));
        end
        drive(0, 0, 16'h0000, 0, 0, 0, 1, 0);
        chk("acc_cnt_saturated", 32'(acc_cnt), 32'd255);
        advance();
        step(0, 0, 16'h0000, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
